mips_cpu: RTL and testbench
===========================

Name: mips_cpu

Overview:
- Single-cycle 32-bit MIPS-subset processor. One instruction completes per rising clock edge.
- Contains a unified word-wide memory instance `memoria`, holding instructions and data, plus a 32x32 register file.
- Top-level block of the CPU subsystem. The bench preloads program words hierarchically into `memoria.memoryFiles` and may write register `PC` directly.

Parameters:
- MEM_ADDR_BITS, 10, number of address bits indexing `memoria.memoryFiles`; depth = 2**MEM_ADDR_BITS entries of 32 bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- pc_out  output  32  current value of internal register `PC`.

Behaviour:
- State:
  - Internal register named `PC`.
  - Register file `regs[0:31]`.
  - Memory instance `memoria`, with array `memoryFiles[0:2**MEM_ADDR_BITS-1]`, 32-bit entries.
  - Memory is indexed directly by byte address bits [MEM_ADDR_BITS-1:0]: instruction k lives at entry 4k, and sequential fetch uses PC+4.
  - Addresses beyond the depth wrap via truncation.
- Simulation start: PC, regs and all memory entries initialise to 0. All-zero instruction executes as NOP.
- Reset (sampled on rising edge while Reset=1):
  - PC <= RESET_PC; all regs <= 0.
  - Memory not cleared; no register or memory write occurs that cycle.
  - Reset has priority over any instruction in flight.
- Fetch: instr = memoryFiles[PC index], combinational read.
- Per edge without reset: PC <= next_pc; writeback and store commit on the same edge.
- R-type (opcode 000000), funct-based:
  - add 100000: rd = rs + rt, 32-bit wrap, no overflow trap.
  - sub 100010: rd = rs - rt.
  - and 100100: rd = rs & rt.
  - or 100101: rd = rs | rt.
  - slt 101010: rd = signed(rs) < signed(rt) ? 1 : 0.
  - Other funct values: NOP (no write).
- I-type:
  - addi 001000: rt = rs + sext(imm).
  - lw 100011: rt = mem[rs + sext(imm)].
  - sw 101011: mem[rs + sext(imm)] <= rt.
  - beq 000100: if rs == rt, next_pc = PC + 4 + (sext(imm) << 2).
- J-type: j 000010: next_pc = {PC+4[31:28], target26, 2'b00}.
- Default next_pc = PC + 4.
- Unknown opcodes: NOP (PC + 4, no writes).
- $0 reads as 0 always; writes to register 0 are discarded.
- Register-file reads are combinational. Read-after-write across consecutive instructions returns the new value, because the write commits at the edge.
- A load/store address with nonzero low bits still indexes memoryFiles[addr index] directly; no alignment exception.

Optional Feature:
- Macro CPU_BNE_EN.
- When defined: opcode 000101 (bne) branches to PC + 4 + (sext(imm) << 2) when rs != rt, otherwise PC + 4.
- When undefined: opcode 000101 is a NOP (PC + 4, no state change).

Test Plan:
- Single add:
  - Stimulus: Reset for 1 cycle; regs[1]=5, regs[2]=7 forced; memoryFiles[0]=add $3,$1,$2 (0x00221820).
  - Required response: after 1 edge, regs[3]=12 and PC=4.
- Two-instruction program:
  - Stimulus: memoryFiles[0]=addi $1,$0,10; memoryFiles[4]=addi $2,$1,-3.
  - Required response: after 2 edges, $1=10, $2=7, PC=8; pc_out tracks 0, 4, 8.
- Memory round-trip:
  - Stimulus: addi $1,$0,0x55; sw $1,64($0); lw $2,64($0).
  - Required response: memoryFiles[64]=0x55, $2=0x55, PC=12.
- Branch and jump:
  - beq $0,$0,+2 at PC 0 -> next PC=12.
  - j 0x10 -> next PC=0x40.
  - beq with rs != rt -> PC+4.
- $0 and NOP handling:
  - addi $0,$0,9 -> $0 still reads 0.
  - Unknown opcode 0x3F -> only PC advances by 4.
- Reset mid-run:
  - Stimulus: assert Reset at PC=8.
  - Required response: next edge PC=0, regs cleared, memory contents unchanged.
  - With CPU_BNE_EN defined: bne $1,$0,-1 with $1=1 -> loops to the same PC.

Source files
------------

// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS-subset CPU with unified word memory `memoria` and 32x32 register file.
// Optional bne support is enabled by defining CPU_BNE_EN.
module mips_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] iaddr,
  input  logic [AW-1:0] daddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   instr,
  output logic [31:0]   rdata
);
  logic [31:0] memoryFiles [0:2**AW-1];

  assign instr = memoryFiles[iaddr];
  assign rdata = memoryFiles[daddr];

  always_ff @(posedge clk) begin
    if (we) memoryFiles[daddr] <= wdata;
  end
endmodule

module mips_cpu #(
  parameter int          MEM_ADDR_BITS = 10,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] pc_out
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [31:0] PC;
  logic [31:0] regs [0:31];

  logic [31:0] instr, mem_rdata;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, rs_val, rt_val, pc_plus4, daddr;
  logic        reg_we, mem_we;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data, next_pc;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign simm     = {{16{instr[15]}}, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign pc_plus4 = PC + 32'd4;
  assign daddr    = rs_val + simm;
  assign pc_out   = PC;

  // Memory is byte-addressed by truncation; no alignment shift is applied.
  mips_mem #(.AW(MEM_ADDR_BITS)) memoria (
    .clk   (Clock),
    .we    (mem_we),
    .iaddr (PC[MEM_ADDR_BITS-1:0]),
    .daddr (daddr[MEM_ADDR_BITS-1:0]),
    .wdata (rt_val),
    .instr (instr),
    .rdata (mem_rdata)
  );

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wr_idx  = rt;
    wr_data = 32'd0;
    next_pc = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        wr_idx = rd;
        reg_we = 1'b1;
        case (funct)
          6'b100000: wr_data = rs_val + rt_val;
          6'b100010: wr_data = rs_val - rt_val;
          6'b100100: wr_data = rs_val & rt_val;
          6'b100101: wr_data = rs_val | rt_val;
          6'b101010: wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default:   reg_we  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we  = 1'b1;
        wr_data = daddr;
      end
      OP_LW: begin
        reg_we  = 1'b1;
        wr_data = mem_rdata;
      end
      OP_SW:  mem_we = ~Reset;
      OP_BEQ: if (rs_val == rt_val) next_pc = pc_plus4 + {simm[29:0], 2'b00};
`ifdef CPU_BNE_EN
      OP_BNE: if (rs_val != rt_val) next_pc = pc_plus4 + {simm[29:0], 2'b00};
`else
      OP_BNE: next_pc = pc_plus4;
`endif
      OP_J:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  // Reset wins over any write; register 0 is never written.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      PC <= next_pc;
      if (reg_we && wr_idx != 5'd0) regs[wr_idx] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: preloads programs into memoria and checks registers, memory and PC.
module tb_mips_cpu;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] pc_out;

  int total = 0;
  int bad   = 0;

  mips_cpu dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .pc_out (pc_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.memoria.memoryFiles[i] = 32'd0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  initial begin
    @(negedge Clock);

    // Reset state and single add
    clear_mem();
    dut.regs[1] = 32'd99;
    dut.PC = 32'h20;
    dut.memoria.memoryFiles[0] = 32'h00221820;
    do_reset();
    check("reset_pc", pc_out, 32'h0);
    check("reset_reg1", dut.regs[1], 32'h0);
    dut.regs[1] = 32'd5;
    dut.regs[2] = 32'd7;
    step(1);
    check("add_rd", dut.regs[3], 32'd12);
    check("add_pc", pc_out, 32'd4);

    // Two-instruction program with read-after-write
    clear_mem();
    dut.memoria.memoryFiles[0] = 32'h2001000A;
    dut.memoria.memoryFiles[4] = 32'h2022FFFD;
    do_reset();
    check("prog_pc0", pc_out, 32'd0);
    step(1);
    check("prog_pc1", pc_out, 32'd4);
    check("prog_r1", dut.regs[1], 32'd10);
    step(1);
    check("prog_pc2", pc_out, 32'd8);
    check("prog_r2", dut.regs[2], 32'd7);

    // Memory round-trip
    clear_mem();
    dut.memoria.memoryFiles[0] = 32'h20010055;
    dut.memoria.memoryFiles[4] = 32'hAC010040;
    dut.memoria.memoryFiles[8] = 32'h8C020040;
    do_reset();
    step(3);
    check("sw_mem", dut.memoria.memoryFiles[64], 32'h55);
    check("lw_r2", dut.regs[2], 32'h55);
    check("mem_pc", pc_out, 32'd12);

    // R-type ALU operations with a negative operand
    clear_mem();
    dut.memoria.memoryFiles[0]  = 32'h00221822;
    dut.memoria.memoryFiles[4]  = 32'h00222024;
    dut.memoria.memoryFiles[8]  = 32'h00222825;
    dut.memoria.memoryFiles[12] = 32'h0022302A;
    dut.memoria.memoryFiles[16] = 32'h0041382A;
    do_reset();
    dut.regs[1] = 32'hFFFFFFFE;
    dut.regs[2] = 32'd3;
    dut.regs[7] = 32'd77;
    step(5);
    check("sub", dut.regs[3], 32'hFFFFFFFB);
    check("and", dut.regs[4], 32'h2);
    check("or", dut.regs[5], 32'hFFFFFFFF);
    check("slt_true", dut.regs[6], 32'h1);
    check("slt_false", dut.regs[7], 32'h0);

    // Branch and jump
    clear_mem();
    dut.memoria.memoryFiles[0]    = 32'h10000002;
    dut.memoria.memoryFiles[12]   = 32'h08000010;
    dut.memoria.memoryFiles[64]   = 32'h10200005;
    do_reset();
    dut.regs[1] = 32'd3;
    step(1);
    check("beq_taken", pc_out, 32'd12);
    step(1);
    check("j_target", pc_out, 32'h40);
    step(1);
    check("beq_not_taken", pc_out, 32'h44);

    // $0 protection, unknown opcode, unknown funct
    clear_mem();
    dut.memoria.memoryFiles[0] = 32'h20000009;
    dut.memoria.memoryFiles[4] = 32'hFC22FFFF;
    dut.memoria.memoryFiles[8] = 32'h00221821;
    do_reset();
    dut.regs[1] = 32'd4;
    dut.regs[2] = 32'h1234;
    dut.regs[3] = 32'h5678;
    step(1);
    check("r0_zero", dut.regs[0], 32'h0);
    check("r0_pc", pc_out, 32'd4);
    step(1);
    check("unk_op_r2", dut.regs[2], 32'h1234);
    check("unk_op_pc", pc_out, 32'd8);
    step(1);
    check("unk_funct_r3", dut.regs[3], 32'h5678);
    check("unk_funct_pc", pc_out, 32'd12);

    // Reset mid-run blocks the store at PC 8
    clear_mem();
    dut.memoria.memoryFiles[0]  = 32'h2001000A;
    dut.memoria.memoryFiles[4]  = 32'h2022FFFD;
    dut.memoria.memoryFiles[8]  = 32'hAC010040;
    dut.memoria.memoryFiles[64] = 32'hDEADBEEF;
    do_reset();
    step(2);
    check("mid_pc_before", pc_out, 32'd8);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check("mid_pc", pc_out, 32'd0);
    check("mid_r1", dut.regs[1], 32'd0);
    check("mid_r2", dut.regs[2], 32'd0);
    check("mid_mem64", dut.memoria.memoryFiles[64], 32'hDEADBEEF);
    check("mid_mem0", dut.memoria.memoryFiles[0], 32'h2001000A);

    // bne behaviour, both with and without the option
    clear_mem();
    dut.memoria.memoryFiles[8] = 32'h1420FFFF;
    do_reset();
    dut.PC = 32'd8;
    dut.regs[1] = 32'd1;
    step(1);
`ifdef CPU_BNE_EN
    check("bne_taken", pc_out, 32'd8);
`else
    check("bne_nop", pc_out, 32'd12);
`endif
    dut.PC = 32'd8;
    dut.regs[1] = 32'd0;
    step(1);
    check("bne_not_taken", pc_out, 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
